// File: rtl/wb_rr_interconnect.sv
// wb_rr_interconnect: round-robin Wishbone classic shared bus with decode-miss error and ack watchdog
`timescale 1ns/1ps
module wb_rr_interconnect #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int SWIDTH      = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic [NUM_MASTERS*AWIDTH-1:0] i_m_adr,
    input  logic [NUM_MASTERS*SWIDTH-1:0] i_m_sel,
    input  logic [NUM_MASTERS-1:0]        i_m_we,
    input  logic [NUM_MASTERS*DWIDTH-1:0] i_m_dat,
    input  logic [NUM_MASTERS-1:0]        i_m_cyc,
    input  logic [NUM_MASTERS-1:0]        i_m_stb,
    output logic [NUM_MASTERS*DWIDTH-1:0] o_m_dat,
    output logic [NUM_MASTERS-1:0]        o_m_ack,
    output logic [NUM_MASTERS-1:0]        o_m_err,
    output logic [AWIDTH-1:0]             o_s_adr,
    output logic [SWIDTH-1:0]             o_s_sel,
    output logic                          o_s_we,
    output logic [DWIDTH-1:0]             o_s_dat,
    output logic [NUM_SLAVES-1:0]         o_s_cyc,
    output logic [NUM_SLAVES-1:0]         o_s_stb,
    input  logic [NUM_SLAVES*DWIDTH-1:0]  i_s_dat,
    input  logic [NUM_SLAVES-1:0]         i_s_ack,
    input  logic [NUM_SLAVES-1:0]         i_s_err,
    output logic [NUM_MASTERS-1:0]        o_grant
);
    localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t            state, state_nx;
    logic [MW-1:0]     gidx, gidx_nx, last, last_nx, pick;
    logic [15:0]       tcnt, tcnt_nx;
    logic              g_cyc, g_stb, g_we;
    logic [AWIDTH-1:0] g_adr;
    logic [SWIDTH-1:0] g_sel;
    logic [DWIDTH-1:0] g_dat, s_dat;
    logic              s_ack, s_err;
    logic [3:0]        sidx;
    logic              hit, act, rtn;

    assign sidx = g_adr[AWIDTH-1 -: 4];
    assign hit  = 32'(sidx) < NUM_SLAVES;
    assign act  = state != IDLE;
    assign rtn  = state == BUSY && hit;

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_sel = '0;
        g_dat = '0;
        for (int m = 0; m < NUM_MASTERS; m++)
            if (gidx == MW'(m)) begin
                g_cyc = i_m_cyc[m];
                g_stb = i_m_stb[m];
                g_we  = i_m_we[m];
                g_adr = i_m_adr[m*AWIDTH +: AWIDTH];
                g_sel = i_m_sel[m*SWIDTH +: SWIDTH];
                g_dat = i_m_dat[m*DWIDTH +: DWIDTH];
            end
        s_dat = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
        for (int s = 0; s < NUM_SLAVES; s++)
            if (sidx == 4'(s)) begin
                s_dat = i_s_dat[s*DWIDTH +: DWIDTH];
                s_ack = i_s_ack[s];
                s_err = i_s_err[s];
            end
    end

    assign o_s_adr = act ? g_adr : '0;
    assign o_s_sel = act ? g_sel : '0;
    assign o_s_we  = act ? g_we : 1'b0;
    assign o_s_dat = act ? g_dat : '0;

    always_comb begin
        o_s_cyc = '0;
        o_s_stb = '0;
        o_m_dat = '0;
        o_m_ack = '0;
        o_m_err = '0;
        o_grant = '0;
        for (int s = 0; s < NUM_SLAVES; s++)
            if (rtn && sidx == 4'(s)) begin
                o_s_cyc[s] = g_cyc;
                o_s_stb[s] = g_stb;
            end
        // slave err overrides a simultaneous ack
        for (int m = 0; m < NUM_MASTERS; m++)
            if (act && gidx == MW'(m)) begin
                o_grant[m]                   = 1'b1;
                o_m_dat[m*DWIDTH +: DWIDTH] = rtn ? s_dat : '0;
                o_m_ack[m]                   = rtn & s_ack & ~s_err;
                o_m_err[m]                   = (rtn & s_err) | (state == ERR);
            end
    end

    always_comb begin
        pick = last;
        for (int i = NUM_MASTERS; i >= 1; i--)
            for (int m = 0; m < NUM_MASTERS; m++)
                if (i_m_cyc[m] && m == (int'(last) + i) % NUM_MASTERS)
                    pick = MW'(m);
        state_nx = state;
        gidx_nx  = gidx;
        last_nx  = last;
        tcnt_nx  = '0;
        if (state == IDLE) begin
            if (|i_m_cyc) begin
                gidx_nx  = pick;
                state_nx = BUSY;
            end
        end else if (!g_cyc) begin
            state_nx = IDLE;
            last_nx  = gidx;
        end else if (state == ERR)
            state_nx = BUSY;
        else if (g_stb && (!hit || (tcnt == 16'(TIMEOUT) && !s_ack && !s_err)))
            state_nx = ERR;
        else if (g_stb && !s_ack && !s_err)
            tcnt_nx = tcnt + 16'd1;
    end

    always_ff @(posedge i_clk or posedge i_arst)
        if (i_arst) begin
            state <= IDLE;
            gidx  <= '0;
            last  <= MW'(NUM_MASTERS - 1);
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            gidx  <= gidx_nx;
            last  <= last_nx;
            tcnt  <= tcnt_nx;
        end
endmodule

// File: tb/tb_wb_rr_interconnect.sv
// tb_wb_rr_interconnect: directed bench with response scoreboard for wb_rr_interconnect (2 masters, 4 slaves, TIMEOUT=8)
`timescale 1ns/1ps
module tb_wb_rr_interconnect;
    logic        clk = 1'b0, arst = 1'b1;
    logic [63:0] m_adr = '0, m_dat = '0, o_m_dat;
    logic [7:0]  m_sel = '0;
    logic [1:0]  m_we = '0, m_cyc = '0, m_stb = '0, o_m_ack, o_m_err, o_grant;
    logic [31:0] o_s_adr, o_s_dat;
    logic [3:0]  o_s_sel, o_s_cyc, o_s_stb, i_s_ack, i_s_err;
    logic        o_s_we;
    logic [127:0] i_s_dat;

    logic [7:0]  cnt [4];
    logic [7:0]  lat [4];
    logic [31:0] sdat [4];
    bit          never [4];
    bit          both [4];

    typedef struct {int m; bit err; logic [31:0] dat;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0, n_err = 0;
    bit   got;

    wb_rr_interconnect #(.NUM_MASTERS(2), .NUM_SLAVES(4), .AWIDTH(32), .DWIDTH(32),
                         .SWIDTH(4), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_arst(arst), .i_m_adr(m_adr), .i_m_sel(m_sel), .i_m_we(m_we),
        .i_m_dat(m_dat), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .o_m_dat(o_m_dat),
        .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_s_adr(o_s_adr), .o_s_sel(o_s_sel),
        .o_s_we(o_s_we), .o_s_dat(o_s_dat), .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
        .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .i_s_err(i_s_err), .o_grant(o_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // behavioural slaves: ack after lat[s] strobed cycles, or never, or ack+err together
    always @(posedge clk)
        for (int s = 0; s < 4; s++)
            cnt[s] <= (o_s_stb[s] && !i_s_ack[s]) ? cnt[s] + 8'd1 : 8'd0;

    always_comb begin
        i_s_ack = '0;
        i_s_err = '0;
        i_s_dat = '0;
        for (int s = 0; s < 4; s++) begin
            i_s_ack[s] = o_s_stb[s] && (both[s] || (!never[s] && cnt[s] == lat[s]));
            i_s_err[s] = o_s_stb[s] && both[s];
            i_s_dat[s*32 +: 32] = sdat[s];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input bit cyc, input logic [31:0] adr,
                         input bit we, input logic [31:0] dat);
        m_cyc[m] = cyc;
        m_stb[m] = cyc;
        m_we[m]  = we;
        m_adr[m*32 +: 32] = adr;
        m_dat[m*32 +: 32] = dat;
        m_sel[m*4 +: 4]   = 4'hF;
    endtask

    task automatic push(input int m, input bit err, input logic [31:0] dat);
        exp_t e;
        e.m = m;
        e.err = err;
        e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic wait_resp(input int m, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            @(negedge clk);
            if (o_m_ack[m] || o_m_err[m]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    always @(negedge clk)
        if (!arst)
            for (int m = 0; m < 2; m++)
                if (o_m_ack[m] || o_m_err[m]) begin
                    chk("ack_err_exclusive", {o_m_ack[m], o_m_err[m]} == 2'b11, 0);
                    chk("resp_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        mon_e = sb.pop_front();
                        chk("resp_master", m, mon_e.m);
                        chk("resp_err", o_m_err[m], mon_e.err);
                        if (!mon_e.err)
                            chk("resp_dat", o_m_dat[m*32 +: 32], mon_e.dat);
                    end
                end

    initial begin
        for (int s = 0; s < 4; s++) begin
            lat[s] = 8'd0;
            sdat[s] = 32'hA0A0_0000 | s;
            never[s] = 1'b0;
            both[s] = 1'b0;
        end
        lat[1] = 8'd2;
        sdat[1] = 32'hCAFE_F00D;

        @(negedge clk);
        chk("rst_grant", o_grant, 0);
        chk("rst_s_cyc_stb", {o_s_cyc, o_s_stb}, 0);
        chk("rst_ack_err", {o_m_ack, o_m_err}, 0);
        chk("rst_m_dat", o_m_dat, 0);
        tick();
        arst = 1'b0;

        // single read of slave 1
        push(0, 0, 32'hCAFE_F00D);
        drive(0, 1, 32'h1000_0004, 0, 0);
        @(negedge clk);
        chk("t1_idle_cyc", o_s_cyc, 0);
        tick();
        @(negedge clk);
        chk("t1_s_cyc", o_s_cyc, 4'b0010);
        chk("t1_s_stb", o_s_stb, 4'b0010);
        chk("t1_s_adr", o_s_adr, 32'h1000_0004);
        wait_resp(0, got);
        chk("t1_got_ack", got, 1);
        chk("t1_ack_with_slave", i_s_ack[1], 1);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();

        // round-robin after reset
        arst = 1'b1;
        tick();
        arst = 1'b0;
        for (int k = 0; k < 4; k++)
            push(k % 2, 0, sdat[0]);
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                @(negedge clk);
                got = |o_m_ack;
            end
            chk("rr_ack_order", o_m_ack, (k % 2) ? 2'b10 : 2'b01);
            tick();
            drive(k % 2, 0, 0, 0, 0);
            tick();
            if (k < 2)
                drive(k % 2, 1, 0, 0, 0);
            @(negedge clk);
            chk("rr_idle_gap", o_grant, 0);
        end

        // master 1 back-to-back writes, master 0 waits
        for (int k = 0; k < 3; k++)
            push(1, 0, sdat[0]);
        push(0, 0, sdat[0]);
        tick();
        drive(1, 1, 32'h0000_0000, 1, 32'h1111_0000);
        tick();
        drive(0, 1, 32'h0000_0010, 0, 0);
        @(negedge clk);
        chk("b2b_ack0", o_m_ack, 2'b10);
        chk("b2b_we", o_s_we, 1);
        chk("b2b_wdat", o_s_dat, 32'h1111_0000);
        tick();
        drive(1, 1, 32'h0000_0004, 1, 32'h1111_0001);
        @(negedge clk);
        chk("b2b_ack1", o_m_ack, 2'b10);
        chk("b2b_adr1", o_s_adr, 32'h0000_0004);
        tick();
        drive(1, 1, 32'h0000_0008, 1, 32'h1111_0002);
        @(negedge clk);
        chk("b2b_ack2", o_m_ack, 2'b10);
        chk("b2b_grant", o_grant, 2'b10);
        tick();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("b2b_hold", o_grant, 2'b10);
        chk("b2b_no_ack", o_m_ack, 0);
        tick();
        @(negedge clk);
        chk("b2b_idle", o_grant, 0);
        tick();
        @(negedge clk);
        chk("b2b_m0_grant", o_grant, 2'b01);
        chk("b2b_m0_ack", o_m_ack, 2'b01);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();

        // decode miss
        push(0, 1, 0);
        drive(0, 1, 32'hF000_0000, 0, 0);
        @(negedge clk);
        chk("miss_idle_stb", o_s_stb, 0);
        tick();
        @(negedge clk);
        chk("miss_busy_stb", o_s_stb, 0);
        chk("miss_busy_err", o_m_err, 0);
        tick();
        @(negedge clk);
        chk("miss_err", o_m_err, 2'b01);
        chk("miss_no_ack", o_m_ack, 0);
        chk("miss_err_stb", o_s_stb, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("miss_err_once", o_m_err, 0);
        tick();

        // ack watchdog on a silent slave
        never[3] = 1'b1;
        push(0, 1, 0);
        drive(0, 1, 32'h3000_0000, 0, 0);
        for (int k = 0; k < 9; k++) begin
            tick();
            @(negedge clk);
            chk("to_stb_held", o_s_stb, 4'b1000);
            chk("to_no_err_yet", o_m_err, 0);
        end
        tick();
        @(negedge clk);
        chk("to_err", o_m_err, 2'b01);
        chk("to_stb_low", o_s_stb, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();

        // simultaneous slave ack and err
        both[2] = 1'b1;
        push(0, 1, 0);
        drive(0, 1, 32'h2000_0000, 0, 0);
        tick();
        @(negedge clk);
        chk("ackerr_err", o_m_err, 2'b01);
        chk("ackerr_no_ack", o_m_ack, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        both[2] = 1'b0;

        // asynchronous reset mid-access
        lat[2] = 8'd3;
        drive(1, 1, 32'h2000_0000, 0, 0);
        tick();
        @(negedge clk);
        chk("arst_pre_stb", o_s_stb, 4'b0100);
        #1;
        arst = 1'b1;
        #1;
        chk("arst_stb", o_s_stb, 0);
        chk("arst_cyc", o_s_cyc, 0);
        chk("arst_grant", o_grant, 0);
        chk("arst_adr", o_s_adr, 0);
        chk("arst_ack_err", {o_m_ack, o_m_err}, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();
        arst = 1'b0;
        push(0, 0, sdat[0]);
        push(1, 0, sdat[0]);
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        tick();
        @(negedge clk);
        chk("arst_prio_grant", o_grant, 2'b01);
        chk("arst_prio_ack", o_m_ack, 2'b01);
        tick();
        drive(0, 0, 0, 0, 0);
        wait_resp(1, got);
        chk("arst_m1_ack", got, 1);
        tick();
        drive(1, 0, 0, 0, 0);
        tick();
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
